rpg_word_scheduler: RTL

- Shares one random_pulse_generator instance among NUM_REQ requesters.
- Grants the generator round-robin and drives its ce for WORD_W cycles.
- Deserialises the generator's q stream into a WORD_W-bit word and returns it to the granted requester with a one-cycle grant/valid pulse.
- Sits between consumers of random words (e.g. key/nonce generation for simon_core, sha3 padding) and the pulse generator.

---
 rtl/rpg_word_scheduler_pkg.sv | 22 ++
 rtl/rpg_word_scheduler_if.sv | 36 +++
 rtl/rpg_word_scheduler_rr_arbiter.sv | 44 ++++
 rtl/rpg_word_scheduler.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rpg_word_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// rpg_sched_pkg
// Shared types and width helpers for the random-word scheduler.
//   state_e : scheduler FSM states (IDLE, FILL, DRAIN, DONE)
//   idx_w() : index width for a count of items (never less than one bit)
// -----------------------------------------------------------------------------
package rpg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request
    FILL  = 2'd1,  // generator enabled, collecting bits
    DRAIN = 2'd2,  // generator idle, capturing the last registered bit
    DONE  = 2'd3   // word presented with the grant pulse
  } state_e;

  // Width needed to index n items; a single item still gets one bit so that
  // every vector declared from this stays a legal, non-zero width.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rpg_word_scheduler_if.sv
// -----------------------------------------------------------------------------
// rpg_word_scheduler_if
// Requester-side bus of the random-word scheduler.
//   req  : level request per requester, held until its grant or withdrawn
//   gnt  : one-hot, one-cycle grant pulse; the word for that requester is on data
//   data : last delivered word, valid in the grant cycle, held afterwards
//   busy : scheduler is in the middle of a transaction
// Modports:
//   master : requester side (drives req)
//   slave  : scheduler side (drives gnt, data, busy)
// -----------------------------------------------------------------------------
interface rpg_word_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [WORD_W-1:0]  data;
  logic               busy;

  modport master (
    output req,
    input  gnt,
    input  data,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output data,
    output busy
  );

endinterface

// File: rtl/rpg_word_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req starting one above last_owner
// and wrapping, so the previous owner has lowest priority.
//   req        in  NUM_REQ  request vector
//   last_owner in  IDX_W    index of the previously granted requester
//   grant      out NUM_REQ  one-hot of the chosen requester (0 if none)
//   idx        out IDX_W    index of the chosen requester (0 if none)
//   found      out 1        at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import rpg_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int cand;

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Offsets 1..NUM_REQ visit every requester once, last_owner last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_owner) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand[IDX_W-1:0];
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rpg_word_scheduler.sv
// -----------------------------------------------------------------------------
// rpg_word_scheduler
// Shares one random_pulse_generator among NUM_REQ requesters. A requester is
// picked round-robin, the generator is enabled for WORD_W cycles, its serial
// q stream is packed MSB-first into a word, and the word is handed back with a
// one-cycle grant pulse.
//   clk     in   1        system clock, rising edge
//   rst     in   1        asynchronous, active-high reset
//   bus     slave         req / gnt / data / busy (rpg_word_scheduler_if)
//   rpg_ce  out  1        generator clock enable
//   rpg_q   in   1        generator output (registered inside the generator)
// Timing for a request seen in IDLE at cycle 0: rpg_ce high cycles 1..WORD_W,
// DRAIN at WORD_W+1, grant at WORD_W+2, back in IDLE at WORD_W+3.
// -----------------------------------------------------------------------------
module rpg_word_scheduler
  import rpg_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rpg_word_scheduler_if.slave  bus,
  output logic                 rpg_ce,
  input  logic                 rpg_q
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int CNT_W = idx_w(WORD_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_W - 1);
  // Starting from the top index makes requester 0 the first choice after reset.
  localparam logic [IDX_W-1:0] OWNER_RST = IDX_W'(NUM_REQ - 1);

  state_e               state_q;
  state_e               state_d;
  logic [NUM_REQ-1:0]   owner_oh_q;    // latched owner, one-hot
  logic [IDX_W-1:0]     last_owner_q;  // round-robin pointer
  logic [CNT_W-1:0]     cnt_q;         // enabled cycles so far in FILL
  logic [WORD_W-1:0]    shreg_q;       // word under construction
  logic [WORD_W-1:0]    data_q;        // last delivered word
  logic                 ce_d_q;        // rpg_ce delayed to line up with q

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_found;
  logic                 owner_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req        (bus.req),
    .last_owner (last_owner_q),
    .grant      (arb_grant),
    .idx        (arb_idx),
    .found      (arb_found)
  );

  // The owner is still asking; dropping it mid-transaction aborts.
  assign owner_req = |(bus.req & owner_oh_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs. All outputs decode the registered state, so the
  // asynchronous reset clears them immediately without waiting for a clock.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rpg_ce   = 1'b0;
    bus.gnt  = '0;
    bus.data = data_q;
    bus.busy = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = FILL;
        end
      end
      FILL: begin
        rpg_ce = 1'b1;
        if (!owner_req) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = owner_req ? DONE : IDLE;
      end
      DONE: begin
        // The freshly completed word is shown in the grant cycle itself;
        // data_q takes it over at the end of this cycle.
        bus.gnt  = owner_oh_q;
        bus.data = shreg_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: owner latch, bit counter, deserialiser, delivered word
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_oh_q   <= '0;
      last_owner_q <= OWNER_RST;
      cnt_q        <= '0;
      shreg_q      <= '0;
      data_q       <= '0;
      ce_d_q       <= 1'b0;
    end else begin
      // q is registered in the generator, so each enabled cycle yields its
      // bit one cycle later.
      ce_d_q <= rpg_ce;

      unique case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          shreg_q <= '0;
          if (arb_found) begin
            owner_oh_q   <= arb_grant;
            // Advanced at grant time, so an aborted owner still loses priority.
            last_owner_q <= arb_idx;
          end
        end
        FILL, DRAIN: begin
          if (state_d == IDLE) begin
            shreg_q <= '0;
          end else if (ce_d_q) begin
            shreg_q <= {shreg_q[WORD_W-2:0], rpg_q};
          end
          if (state_q == FILL) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          data_q <= shreg_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
